// File: rtl/cadr_pkg.sv
// Shared CADR sequencer definitions.
// Holds the cycle-sequencer state encoding and the phase count so that the
// debug and trace blocks decode the same values as cycle_seq.
package cadr_pkg;

    localparam int NUM_PHASES = 6;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_ALU    = 3'd4,
        ST_WRITE  = 3'd5,
        ST_MMU    = 3'd6
    } seq_state_e;

    // Phase-strobe bit positions within a NUM_PHASES-wide vector.
    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_READ   = 2;
    localparam int PH_ALU    = 3;
    localparam int PH_WRITE  = 4;
    localparam int PH_MMU    = 5;

endpackage

// File: rtl/cycle_seq_icount.sv
// Retired-instruction counter for cycle_seq.
// Only compiled when CYCLE_SEQ_ICOUNT_EN is defined, so the default build
// carries no counter flops at all.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high clear
//   inc_i    in   one-cycle retirement pulse
//   count_o  out  32-bit count, wraps 0xFFFFFFFF -> 0
`ifdef CYCLE_SEQ_ICOUNT_EN
module cycle_seq_icount (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/cycle_seq.sv
// CADR processor cycle sequencer.
// Steps each instruction through FETCH, DECODE, READ, ALU, WRITE and an
// optional MMU cycle, and parks in HALTED for debug halt / single step.
// Optional retired-instruction counter: define CYCLE_SEQ_ICOUNT_EN.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   fetch_wait        instruction memory not ready, holds FETCH
//   need_mmu          instruction has a memory cycle, sampled in WRITE
//   mem_busy          holds MMU
//   halt_req          stop at the next instruction boundary
//   step_req          single-step pulse, only honoured in HALTED
//   state_*           one-hot phase strobes, decoded from the state register
//   halted            sequencer is in HALTED
//   instr_done        pulse in the cycle an instruction retires
//   icount            retired-instruction count (0 when counter not built)
//
// state   | meaning
// HALTED  | parked at an instruction boundary, waiting for run or step
// FETCH   | instruction fetch, extended by fetch_wait
// DECODE  | decode, one cycle
// READ    | operand read, one cycle
// ALU     | execute, one cycle
// WRITE   | writeback; retires here unless a memory cycle is needed
// MMU     | memory cycle, extended by mem_busy; retires when it finishes
module cycle_seq
    import cadr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_wait,
    input  logic        need_mmu,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        step_req,
    output logic        state_fetch,
    output logic        state_decode,
    output logic        state_read,
    output logic        state_alu,
    output logic        state_write,
    output logic        state_mmu,
    output logic        halted,
    output logic        instr_done,
    output logic [31:0] icount
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       instr_end;
    logic [NUM_PHASES-1:0] phase;

    // Both the next state and the retirement pulse come from the same
    // decision so they can never disagree about where an instruction ends.
    always_comb begin
        state_d   = state_q;
        instr_end = 1'b0;
        unique case (state_q)
            ST_HALTED: begin
                if (!halt_req || step_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fetch_wait) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_READ;
            ST_READ:   state_d = ST_ALU;
            ST_ALU:    state_d = ST_WRITE;
            ST_WRITE: begin
                if (need_mmu) begin
                    state_d = ST_MMU;
                end else begin
                    instr_end = 1'b1;
                end
            end
            ST_MMU: begin
                if (!mem_busy) begin
                    instr_end = 1'b1;
                end
            end
            default: state_d = ST_HALTED;
        endcase
        // halt_req is only looked at on the boundary, so a late halt never
        // aborts an instruction and a step under halt runs exactly one.
        if (instr_end) begin
            state_d = halt_req ? ST_HALTED : ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        phase = '0;
        phase[PH_FETCH]  = (state_q == ST_FETCH);
        phase[PH_DECODE] = (state_q == ST_DECODE);
        phase[PH_READ]   = (state_q == ST_READ);
        phase[PH_ALU]    = (state_q == ST_ALU);
        phase[PH_WRITE]  = (state_q == ST_WRITE);
        phase[PH_MMU]    = (state_q == ST_MMU);
    end

    assign state_fetch  = phase[PH_FETCH];
    assign state_decode = phase[PH_DECODE];
    assign state_read   = phase[PH_READ];
    assign state_alu    = phase[PH_ALU];
    assign state_write  = phase[PH_WRITE];
    assign state_mmu    = phase[PH_MMU];
    assign halted       = (state_q == ST_HALTED);

    // An instruction caught by reset is abandoned, not retired.
    assign instr_done   = instr_end && !reset;

`ifdef CYCLE_SEQ_ICOUNT_EN
    cycle_seq_icount u_icount (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (instr_done),
        .count_o (icount)
    );
`else
    assign icount = 32'd0;
`endif

endmodule

// File: tb/tb_cycle_seq.sv
module tb_cycle_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_wait, need_mmu, mem_busy, halt_req, step_req;
    logic        state_fetch, state_decode, state_read, state_alu, state_write, state_mmu;
    logic        halted, instr_done;
    logic [31:0] icount;

    int errors = 0;
    int checks = 0;

    // Reference model: "idle" flag plus the position inside the instruction
    // (0 fetch, 1 decode, 2 read, 3 alu, 4 write, 5 memory cycle).
    bit          m_idle;
    int          m_pos;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    cycle_seq dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_wait   (fetch_wait),
        .need_mmu     (need_mmu),
        .mem_busy     (mem_busy),
        .halt_req     (halt_req),
        .step_req     (step_req),
        .state_fetch  (state_fetch),
        .state_decode (state_decode),
        .state_read   (state_read),
        .state_alu    (state_alu),
        .state_write  (state_write),
        .state_mmu    (state_mmu),
        .halted       (halted),
        .instr_done   (instr_done),
        .icount       (icount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs for the current cycle
    // against the model, advance the model, then cross the rising edge.
    task automatic cyc(input bit fw, input bit nm, input bit mb,
                       input bit hr, input bit sr, input bit rs);
        logic [5:0] exp_ph;
        bit         exp_done;
        bit         fin;
        fetch_wait = fw; need_mmu = nm; mem_busy = mb;
        halt_req = hr; step_req = sr; reset = rs;
        #1;
        exp_ph   = m_idle ? 6'd0 : 6'(1 << m_pos);
        fin      = !m_idle && ((m_pos == 4 && !nm) || (m_pos == 5 && !mb));
        exp_done = fin && !rs;
        check("strobes", {26'd0, state_mmu, state_write, state_alu, state_read,
                          state_decode, state_fetch}, {26'd0, exp_ph});
        check("halted", {31'd0, halted}, {31'd0, m_idle});
        check("instr_done", {31'd0, instr_done}, {31'd0, exp_done});
`ifdef CYCLE_SEQ_ICOUNT_EN
        check("icount", icount, m_cnt);
`else
        check("icount", icount, 32'd0);
`endif
        if (rs) begin
            m_idle = 1'b1; m_pos = 0; m_cnt = 32'd0;
        end else if (m_idle) begin
            if (!hr || sr) begin m_idle = 1'b0; m_pos = 0; end
        end else if (fin) begin
            m_idle = hr; m_pos = 0; m_cnt = m_cnt + 32'd1;
        end else if (m_pos == 0) begin
            if (!fw) m_pos = 1;
        end else if (m_pos == 4) begin
            m_pos = 5;
        end else if (m_pos != 5) begin
            m_pos = m_pos + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_idle = 1'b1; m_pos = 0; m_cnt = 32'd0;
        fetch_wait = 0; need_mmu = 0; mem_busy = 0; halt_req = 1; step_req = 0; reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_idle = 1'b1; m_pos = 0; m_cnt = 32'd0;

        // Reset held; outputs must show HALTED.
        cyc(0, 0, 0, 1, 0, 1);
        // Basic 5-cycle instruction: HALTED, FETCH..WRITE, retire.
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
`ifdef CYCLE_SEQ_ICOUNT_EN
        check("icount_after_first", icount, 32'd1);
`endif
        // Memory cycle with 3 busy cycles: MMU held for 4.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);   // FETCH..ALU
        cyc(0, 1, 1, 0, 0, 0);                               // WRITE -> MMU
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0);   // MMU busy
        cyc(0, 0, 0, 0, 0, 0);                               // MMU done
        check("fetch_after_mmu", {31'd0, state_fetch}, 32'd1);
        // fetch_wait for 2 cycles: FETCH lasts 3.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("decode_after_wait", {31'd0, state_decode}, 32'd1);
        // Halt raised in READ: instruction completes, then HALTED.
        cyc(0, 0, 0, 0, 0, 0);                               // DECODE
        cyc(0, 0, 0, 1, 1, 0);                               // READ, stray step ignored
        cyc(0, 0, 0, 1, 0, 0);                               // ALU
        cyc(0, 0, 0, 1, 0, 0);                               // WRITE
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);   // HALTED
        // Single step under halt: one instruction, back to HALTED.
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 0, 0);
        check("halted_after_step", {31'd0, halted}, 32'd1);

`ifdef CYCLE_SEQ_ICOUNT_EN
        // Counter wrap: preload all-ones while idle, retire one instruction.
        force dut.u_icount.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_icount.count_q;
        m_cnt = 32'hFFFF_FFFF;
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
        check("icount_wrap", icount, 32'd0);
`endif

        // Reset during an MMU stall.
        cyc(0, 0, 0, 0, 0, 0);                               // HALTED -> FETCH
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);                               // WRITE -> MMU
        cyc(0, 0, 1, 0, 0, 0);                               // MMU busy
        cyc(0, 0, 1, 0, 0, 1);                               // reset while busy
        check("halted_after_mmu_reset", {31'd0, halted}, 32'd1);
        check("icount_after_mmu_reset", icount, 32'd0);
        cyc(0, 0, 1, 1, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
